// File: rtl/ahbl_pkg.sv
// AHB-Lite transfer encodings and XIP line-cache FSM state type.
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StResp = 2'd2
  } cache_state_e;

  function automatic logic htrans_active(input logic [1:0] htrans);
    case (htrans)
      HTRANS_NONSEQ, HTRANS_SEQ: return 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  return 1'b0;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/xip_line_cache_store.sv
// Tag/valid registers and line data array; one write port, one asynchronous read port.
module xip_line_cache_store #(
  parameter int unsigned NUM_LINES  = 16,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned TAG_W      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic                          we_i,
  input  logic [$clog2(NUM_LINES)-1:0]  widx_i,
  input  logic [$clog2(LINE_WORDS)-1:0] wword_i,
  input  logic [31:0]                   wdata_i,
  input  logic                          tag_we_i,
  input  logic [TAG_W-1:0]              tag_i,
  input  logic                          valid_i,
  input  logic [$clog2(NUM_LINES)-1:0]  ridx_i,
  input  logic [$clog2(LINE_WORDS)-1:0] rword_i,
  output logic [31:0]                   rdata_o,
  output logic [TAG_W-1:0]              rtag_o,
  output logic                          rvalid_o
);

  logic [31:0]      data_q [NUM_LINES][LINE_WORDS];
  logic [TAG_W-1:0] tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      data_q[widx_i][wword_i] <= wdata_i;
    end
    if (tag_we_i) begin
      tag_q[widx_i] <= tag_i;
    end
  end

  // A global clear wins over a same-cycle line install.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (clear_i) begin
      valid_q <= '0;
    end else if (tag_we_i) begin
      valid_q[widx_i] <= valid_i;
    end
  end

  assign rdata_o  = data_q[ridx_i][rword_i];
  assign rtag_o   = tag_q[ridx_i];
  assign rvalid_o = valid_q[ridx_i];

endmodule

// File: rtl/xip_line_cache_ahbl.sv
// Read-only direct-mapped line cache between upstream AHB-Lite and the QSPI XIP controller.
module xip_line_cache_ahbl import ahbl_pkg::*; #(
  parameter int unsigned NUM_LINES  = 16,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 24
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic        M_HSEL,
  output logic [31:0] M_HADDR,
  output logic [1:0]  M_HTRANS,
  input  logic        M_HREADY,
  input  logic [31:0] M_HRDATA,
  input  logic        flush
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = ADDR_W - OFF_W - IDX_W - 2;
  localparam int unsigned CNT_W = OFF_W + 1;

  cache_state_e     state_q, state_d;
  logic             rd_pend_q;
  logic [OFF_W-1:0] off_q;
  logic [IDX_W-1:0] idx_q;
  logic [TAG_W-1:0] tag_q;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [OFF_W-1:0] data_cnt_q, data_cnt_d;
  logic             data_pend_q, data_pend_d;
  logic             fill_flush_q, fill_flush_d;

  logic              accept, hit, issuing, capture, last_word;
  logic              st_tag_we, st_valid;
  logic [31:0]       st_rdata;
  logic [TAG_W-1:0]  st_rtag;
  logic              st_rvalid;
  logic [ADDR_W-1:0] fill_addr;
  logic              unused_addr;

  assign unused_addr = ^{HADDR[31:ADDR_W], HADDR[1:0]};

  assign accept    = HSEL & htrans_active(HTRANS) & HREADY;
  assign hit       = st_rvalid & (st_rtag == tag_q);
  assign issuing   = (state_q == StFill) && (issue_cnt_q < CNT_W'(LINE_WORDS));
  assign capture   = (state_q == StFill) && data_pend_q && M_HREADY;
  assign last_word = data_cnt_q == OFF_W'(LINE_WORDS - 1);
  assign fill_addr = {tag_q, idx_q, issue_cnt_q[OFF_W-1:0], 2'b00};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rd_pend_q <= 1'b0;
      off_q     <= '0;
      idx_q     <= '0;
      tag_q     <= '0;
    end else if (HREADY) begin
      rd_pend_q <= accept & ~HWRITE;
      if (accept) begin
        {tag_q, idx_q, off_q} <= HADDR[ADDR_W-1:2];
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= StIdle;
      issue_cnt_q  <= '0;
      data_cnt_q   <= '0;
      data_pend_q  <= 1'b0;
      fill_flush_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      data_cnt_q   <= data_cnt_d;
      data_pend_q  <= data_pend_d;
      fill_flush_q <= fill_flush_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    issue_cnt_d  = issue_cnt_q;
    data_cnt_d   = data_cnt_q;
    data_pend_d  = data_pend_q;
    fill_flush_d = fill_flush_q | flush;
    unique case (state_q)
      StIdle: begin
        if (rd_pend_q && !hit) begin
          state_d      = StFill;
          issue_cnt_d  = '0;
          data_cnt_d   = '0;
          data_pend_d  = 1'b0;
          fill_flush_d = 1'b0;
        end
      end
      StFill: begin
        // Address and data phases share M_HREADY, so both advance together.
        if (M_HREADY) begin
          data_pend_d = issuing;
          if (issuing) begin
            issue_cnt_d = issue_cnt_q + CNT_W'(1);
          end
        end
        if (capture) begin
          data_cnt_d = data_cnt_q + OFF_W'(1);
          if (last_word) begin
            state_d = StResp;
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRDATA    = '0;
    M_HSEL    = 1'b0;
    M_HTRANS  = HTRANS_IDLE;
    M_HADDR   = '0;
    unique case (state_q)
      StIdle: begin
        if (rd_pend_q) begin
          if (hit) begin
            HRDATA = st_rdata;
          end else begin
            HREADYOUT = 1'b0;
          end
        end
      end
      StFill: begin
        HREADYOUT = 1'b0;
        M_HSEL    = issuing | data_pend_q;
        if (issuing) begin
          M_HTRANS = HTRANS_NONSEQ;
          M_HADDR  = 32'(fill_addr);
        end
      end
      StResp:  HRDATA = st_rdata;
      default: ;
    endcase
  end

  assign HRESP     = 1'b0;
  assign st_tag_we = capture & last_word;
  // A flush seen anywhere in the fill leaves the fetched line unusable for later hits.
  assign st_valid  = ~(fill_flush_q | flush);

  xip_line_cache_store #(
    .NUM_LINES  (NUM_LINES),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (TAG_W)
  ) u_store (
    .clk_i    (HCLK),
    .rst_ni   (HRESETn),
    .clear_i  (flush),
    .we_i     (capture),
    .widx_i   (idx_q),
    .wword_i  (data_cnt_q),
    .wdata_i  (M_HRDATA),
    .tag_we_i (st_tag_we),
    .tag_i    (tag_q),
    .valid_i  (st_valid),
    .ridx_i   (idx_q),
    .rword_i  (off_q),
    .rdata_o  (st_rdata),
    .rtag_o   (st_rtag),
    .rvalid_o (st_rvalid)
  );

endmodule

// File: tb/tb_xip_line_cache_ahbl.sv
// Scoreboard bench for xip_line_cache_ahbl with a pipelined AHB master and flash slave model.
module tb_xip_line_cache_ahbl;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic        M_HSEL;
  logic [31:0] M_HADDR;
  logic [1:0]  M_HTRANS;
  logic        M_HREADY;
  logic [31:0] M_HRDATA;
  logic        flush;

  xip_line_cache_ahbl #(
    .NUM_LINES  (16),
    .LINE_WORDS (4),
    .ADDR_W     (24)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA),
    .HRESP     (HRESP),
    .M_HSEL    (M_HSEL),
    .M_HADDR   (M_HADDR),
    .M_HTRANS  (M_HTRANS),
    .M_HREADY  (M_HREADY),
    .M_HRDATA  (M_HRDATA),
    .flush     (flush)
  );

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  function automatic logic [31:0] flash_word(input logic [23:0] a);
    return {~a[15:0], a[23:16], a[7:0]} ^ 32'h1234_5678;
  endfunction

  // Downstream flash slave: pipelined, optional random wait states.
  bit          stall_en = 1'b0;
  logic        dp_valid;
  logic [31:0] dp_addr;
  logic [31:0] ds_q[$];
  int          ds_rd = 0;

  always @(negedge HCLK) M_HREADY <= stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_addr  <= '0;
    end else if (M_HREADY) begin
      dp_valid <= M_HSEL && (M_HTRANS == 2'b10);
      dp_addr  <= M_HADDR;
    end
  end

  always @(posedge HCLK) begin
    if (HRESETn && M_HSEL && (M_HTRANS == 2'b10) && M_HREADY) ds_q.push_back(M_HADDR);
  end

  assign M_HRDATA = dp_valid ? flash_word(dp_addr[23:0]) : 32'hDEAD_BEEF;

  int chk_cnt = 0;
  int err_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Cache model and scoreboard.
  typedef struct {
    logic [31:0] data;
    int          waits;
    bit          is_write;
  } exp_t;

  exp_t        sb[$];
  bit          mv[16];
  logic [15:0] mt[16];

  task automatic model_clear();
    for (int k = 0; k < 16; k++) mv[k] = 1'b0;
  endtask

  task automatic sb_push(input logic [31:0] addr, input bit wr);
    exp_t e;
    logic [3:0]  idx;
    logic [15:0] tag;
    bit          hit;
    idx = addr[7:4];
    tag = addr[23:8];
    e.is_write = wr;
    e.data     = wr ? 32'h0 : flash_word({addr[23:2], 2'b00});
    if (wr) begin
      e.waits = 0;
    end else begin
      hit     = mv[idx] && (mt[idx] == tag);
      e.waits = hit ? 0 : (stall_en ? -1 : 6);
      if (!hit) begin
        mv[idx] = 1'b1;
        mt[idx] = tag;
      end
    end
    sb.push_back(e);
  endtask

  logic [31:0] seq_addr[4];
  bit          seq_wr[4];
  int          seq_flush_at = -1;
  int          seq_ff_after = -1;

  // Pipelined master: address i is driven during the data phase of i-1.
  task automatic run_seq(input int n);
    exp_t e;
    int   waits;
    for (int i = 0; i <= n; i++) begin
      @(negedge HCLK);
      flush = 1'b0;
      if (i > 0 && (i - 1) == seq_flush_at) begin
        flush = 1'b1;
        model_clear();
      end
      if (i < n) begin
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = seq_addr[i]; HWRITE = seq_wr[i];
        sb_push(seq_addr[i], seq_wr[i]);
      end else begin
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
      end
      if (i > 0) begin
        waits = 0;
        while (!HREADYOUT && waits < 200) begin
          @(negedge HCLK);
          waits++;
          flush = (waits == seq_ff_after);
        end
        e = sb.pop_front();
        if (waits >= 200) check_eq("timeout", 32'(waits), 32'(e.waits));
        check_eq("hresp", {31'b0, HRESP}, 32'h0);
        if (!e.is_write) check_eq("hrdata", HRDATA, e.data);
        if (e.waits >= 0) check_eq("waits", 32'(waits), 32'(e.waits));
      end
    end
    flush        = 1'b0;
    seq_flush_at = -1;
    seq_ff_after = -1;
  endtask

  task automatic rd1(input logic [31:0] a);
    seq_addr[0] = a; seq_wr[0] = 1'b0;
    run_seq(1);
  endtask

  task automatic ds_expect_line(input logic [31:0] base);
    for (int k = 0; k < 4; k++) begin
      if (ds_rd < ds_q.size()) begin
        check_eq("ds_addr", ds_q[ds_rd], base + 32'(4 * k));
        ds_rd++;
      end else begin
        check_eq("ds_count", 32'(ds_q.size()), 32'(ds_rd + 1));
      end
    end
  endtask

  task automatic ds_none();
    check_eq("ds_extra", 32'(ds_q.size()), 32'(ds_rd));
    ds_rd = ds_q.size();
  endtask

  initial begin
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0; flush = 1'b0;
    model_clear();
    repeat (3) @(negedge HCLK);
    check_eq("rst_hreadyout", {31'b0, HREADYOUT}, 32'h1);
    check_eq("rst_hrdata", HRDATA, 32'h0);
    check_eq("rst_hresp", {31'b0, HRESP}, 32'h0);
    check_eq("rst_m_hsel", {31'b0, M_HSEL}, 32'h0);
    check_eq("rst_m_htrans", {30'b0, M_HTRANS}, 32'h0);
    check_eq("rst_m_haddr", M_HADDR, 32'h0);
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);

    // Cold miss, then hit in the same line.
    rd1(32'h0000_0010);
    ds_expect_line(32'h10);
    ds_none();
    rd1(32'h0000_0014);
    ds_none();

    // Conflicting tags on one index, back to back.
    seq_addr[0] = 32'h0000_0110; seq_wr[0] = 1'b0;
    seq_addr[1] = 32'h0000_0010; seq_wr[1] = 1'b0;
    run_seq(2);
    ds_expect_line(32'h110);
    ds_expect_line(32'h10);
    ds_none();

    // Flush during a hit still returns hit data; the next access misses.
    seq_addr[0] = 32'h0000_0014; seq_wr[0] = 1'b0;
    seq_addr[1] = 32'h0000_0018; seq_wr[1] = 1'b0;
    seq_flush_at = 0;
    run_seq(2);
    ds_expect_line(32'h10);
    ds_none();

    // Idle flush pulse, then refill.
    @(negedge HCLK); flush = 1'b1; model_clear();
    @(negedge HCLK); flush = 1'b0;
    rd1(32'h0000_0014);
    ds_expect_line(32'h10);
    ds_none();

    // Flush mid-fill: read answered, line not retained.
    seq_ff_after = 3;
    rd1(32'h0000_0024);
    model_clear();
    rd1(32'h0000_0024);
    ds_expect_line(32'h20);
    ds_expect_line(32'h20);
    ds_none();

    // Write is absorbed without downstream traffic.
    seq_addr[0] = 32'h0000_0010; seq_wr[0] = 1'b1;
    run_seq(1);
    ds_none();
    rd1(32'h0000_0010);
    rd1(32'h0000_0010);

    // Random traffic with and without downstream stalls.
    for (int r = 0; r < 24; r++) begin
      stall_en = (r >= 12);
      seq_addr[0] = 32'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 2));
      seq_wr[0]   = 1'b0;
      seq_addr[1] = 32'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 2));
      seq_wr[1]   = ($urandom_range(0, 4) == 0);
      run_seq(2);
    end
    stall_en = 1'b0;
    repeat (2) @(negedge HCLK);
    ds_rd = ds_q.size();

    // Reset in the middle of a fill.
    @(negedge HCLK); HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_3000; HWRITE = 1'b0;
    @(negedge HCLK); HSEL = 1'b0; HTRANS = 2'b00;
    repeat (2) @(negedge HCLK);
    check_eq("fill_htrans", {30'b0, M_HTRANS}, 32'h2);
    check_eq("fill_hreadyout", {31'b0, HREADYOUT}, 32'h0);
    HRESETn = 1'b0;
    #1;
    check_eq("rstfill_htrans", {30'b0, M_HTRANS}, 32'h0);
    check_eq("rstfill_hsel", {31'b0, M_HSEL}, 32'h0);
    check_eq("rstfill_hreadyout", {31'b0, HREADYOUT}, 32'h1);
    @(negedge HCLK);
    HRESETn = 1'b1;
    model_clear();
    @(negedge HCLK);
    ds_rd = ds_q.size();
    rd1(32'h0000_0010);
    ds_expect_line(32'h10);
    ds_none();

    repeat (2) @(negedge HCLK);
    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
